// File: rtl/seven_seg_readback.sv
// seven_seg_readback: recovers per-position BCD digits from a multiplexed active-low seven-segment bus
module seven_seg_readback #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seven_seg,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    capture_stb,
  output logic                    frame_done,
  output logic                    err_sticky,
  output logic [NUM_DIGITS-1:0]   err_pos
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [NUM_DIGITS+6:0] r_smp, r_smp_d;
  logic [NUM_DIGITS-1:0] r_mask, w_mask, w_low;
  logic [3:0]            w_val;
  logic                  w_chg, w_cap, w_single, w_legal, w_blank, w_err;
  assign w_chg    = r_smp != r_smp_d;
  assign w_low    = ~r_smp[NUM_DIGITS+6:7];
  assign w_single = $onehot(w_low);
  assign w_blank  = &r_smp[6:0];
  assign w_cap    = (r_state == SETTLE) && (w_next == CAPTURE);
  assign w_err    = w_cap && !(w_single && (w_legal || w_blank));
  assign w_mask   = r_mask | ((w_cap && w_single) ? w_low : '0);
  // cathode pattern to BCD value; anything not in the table is illegal
  always_comb begin
    w_legal = 1'b1;
    w_val   = 4'd0;
    case (r_smp[6:0])
      7'b1000000: w_val = 4'd0;
      7'b1111001: w_val = 4'd1;
      7'b0100100: w_val = 4'd2;
      7'b0110000: w_val = 4'd3;
      7'b0011001: w_val = 4'd4;
      7'b0010010: w_val = 4'd5;
      7'b0000010: w_val = 4'd6;
      7'b1111000: w_val = 4'd7;
      7'b0000000: w_val = 4'd8;
      7'b0010000: w_val = 4'd9;
      default:    w_legal = 1'b0;
    endcase
  end
  // stability tracking; capture fires on the edge the last required identical sample is confirmed
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    if (w_chg) begin
      w_next = (&r_smp[NUM_DIGITS+6:7]) ? IDLE : SETTLE;
      w_cnt  = '0;
    end else if (r_state == SETTLE) begin
      if (r_cnt == CW'(STABLE_CYCLES - 2)) w_next = CAPTURE;
      else w_cnt = r_cnt + 1'b1;
    end else if (r_state == CAPTURE) w_next = HOLD;
    else if (r_state == HOLD && !(&r_cnt)) w_cnt = r_cnt + 1'b1;
  end
  // state, counter and bus sample pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_smp   <= '1;
      r_smp_d <= '1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_smp   <= {an, seven_seg};
      r_smp_d <= r_smp;
    end
  end
  // capture results: digit registers, frame mask and sticky error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_valid <= '0;
      r_mask      <= '0;
      capture_stb <= 1'b0;
      frame_done  <= 1'b0;
      err_sticky  <= 1'b0;
      err_pos     <= '0;
    end else begin
      capture_stb <= w_cap;
      frame_done  <= w_cap && (&w_mask);
      r_mask      <= (&w_mask) ? '0 : w_mask;
      for (int p = 0; p < NUM_DIGITS; p++)
        if (w_cap && w_single && w_low[p]) begin
          digit_valid[p] <= w_legal;
          if (w_legal) digits[4*p +: 4] <= w_val;
        end
      if (w_err) begin
        err_sticky <= 1'b1;
        if (!err_sticky || clr_err) err_pos <= w_low;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
        err_pos    <= '0;
      end
    end
  end
endmodule
